// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage: data width,
// sequencing FSM states and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_QUOT_ALL_ONES = '1;

endpackage

// File: rtl/div_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of {dividend, divisor}, wrap-around pointers,
// occupancy count. Overflowing pushes and underflowing pops are ignored.
module div_operand_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [2*WIDTH-1:0]         push_data,
  input  logic                       pop,
  output logic [2*WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves the count unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/div_issue_stage.sv
// Sequencer for an external combinational divider: buffers operand pairs, waits
// SETTLE_CYCLES, registers results. Optional DIV_ZERO_CHECK_EN overrides zero-divisor results.
module div_issue_stage
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_dividend,
  input  logic [WIDTH-1:0]       in_divisor,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_quotient,
  output logic [WIDTH-1:0]       out_remainder,
  output logic                   out_div_zero,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             out_valid_q, out_valid_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_head;

  div_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data ({in_dividend, in_divisor}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready      = !fifo_full;
  assign div_dividend  = div_a_q;
  assign div_divisor   = div_b_q;
  assign out_valid     = out_valid_q;
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_div_zero  = dz_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
`ifdef DIV_ZERO_CHECK_EN
          if (div_b_q == '0) begin
            quot_d = WIDTH'(DIV_QUOT_ALL_ONES);
            rem_d  = div_a_q;
            dz_d   = 1'b1;
          end else begin
            quot_d = div_quotient;
            rem_d  = div_remainder;
            dz_d   = 1'b0;
          end
`else
          quot_d = div_quotient;
          rem_d  = div_remainder;
          dz_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fifo_pop    = !fifo_empty;
          state_d     = fifo_empty ? ST_IDLE : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any pop launches the head pair into the divider and restarts settling.
    if (fifo_pop) begin
      div_a_d = fifo_head[2*WIDTH-1:WIDTH];
      div_b_d = fifo_head[WIDTH-1:0];
      cnt_d   = SETTLE_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Bench for div_issue_stage: directed latency/stall/reset cases plus randomized
// traffic, scored against an arithmetic reference and an in-order result queue.
module tb_div_issue_stage;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_dividend, in_divisor;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic         out_valid, out_ready, out_div_zero;
  logic [W-1:0] out_quotient, out_remainder;
  logic [$clog2(D):0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W:0] exp_q[$];
  int           out_cyc[$];
  logic         stall_prev = 1'b0;
  logic [2*W:0] held = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .fifo_count    (fifo_count)
  );

  // Stand-in for the combinational divider; a zero divisor yields junk (0,0).
  always_comb begin
    div_quotient  = '0;
    div_remainder = '0;
    if (div_divisor != '0) begin
      div_quotient  = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
    end
  end

  // Expected {div_zero, quotient, remainder} for one operand pair.
  function automatic logic [2*W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b != '0) return {1'b0, a / b, a % b};
`ifdef DIV_ZERO_CHECK_EN
    return {1'b1, 4'hF, a};
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid || fifo_count != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
  endtask

  // Push into an idle, empty stage and measure edges until out_valid.
  task automatic lat_test(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
    int lat;
    out_ready = 1'b1;
    push_pair(a, b);
    step();
    lat = 1;
    chk("div_dividend", div_dividend, a);
    chk("div_divisor", div_divisor, b);
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 3);
    chk("lat_quot", out_quotient, eq);
    chk("lat_rem", out_remainder, er);
    chk("lat_dz", out_div_zero, 0);
    wait_idle();
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", in_ready, fifo_count != 3'(D));
      if (stall_prev)
        chk("hold_stable", {out_valid, out_div_zero, out_quotient, out_remainder}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("result", {out_div_zero, out_quotient, out_remainder}, exp_q.pop_front());
          out_cyc.push_back(cyc);
          $display("xfer q=%0d r=%0d dz=%0d", out_quotient, out_remainder, out_div_zero);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_div_zero, out_quotient, out_remainder};
      if (in_valid && in_ready) exp_q.push_back(ref_result(in_dividend, in_divisor));
    end
  end

  initial begin
    logic [W-1:0] a, b;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_div", {div_dividend, div_divisor}, 0);
    chk("rst_out", {out_div_zero, out_quotient, out_remainder}, 0);
    rst_n = 1'b1;
    step();

    // Single pair, nominal latency.
    lat_test(4'd6, 4'd2, 4'd3, 4'd0);

    // Back-to-back pairs: in order, one result per SETTLE_CYCLES+1 edges.
    out_cyc.delete();
    out_ready = 1'b1;
    push_pair(4'd6, 4'd2);
    push_pair(4'd7, 4'd2);
    wait_idle();
    chk("b2b_count", out_cyc.size(), 2);
    if (out_cyc.size() == 2) chk("b2b_spacing", out_cyc[1] - out_cyc[0], 3);

    // Backpressure: fill the FIFO behind a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
    chk("stall_count", fifo_count, 4);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    in_valid    = 1'b1;
    in_dividend = 4'd13;
    in_divisor  = 4'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_hold_count", fifo_count, 4);
    end
    out_ready = 1'b1;
    push_pair(4'd13, 4'd4);
    wait_idle();

    // Zero divisor.
    push_pair(4'd9, 4'd0);
    wait_idle();
    chk("dz_quot", out_quotient, ref_result(4'd9, 4'd0) >> W);
    chk("dz_rem", out_remainder, 4'(ref_result(4'd9, 4'd0)));
    chk("dz_flag", out_div_zero, ref_result(4'd9, 4'd0) >> (2 * W));

    // Reset in SETTLE with two pairs buffered.
    out_ready = 1'b0;
    push_pair(4'd8, 4'd3);
    push_pair(4'd11, 4'd5);
    push_pair(4'd15, 4'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_div", {div_dividend, div_divisor}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    lat_test(4'd7, 4'd2, 4'd3, 4'd1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      in_valid    = ($urandom_range(0, 1) == 1);
      in_dividend = a;
      in_divisor  = b;
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("final_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
